// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants and default datapath sizes shared by the decode stage
package mips_pkg;
  localparam int DEF_SIZE = 32;
  localparam int DEF_NUM_REGISTERS = 32;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_SB    = 6'd40;
  localparam logic [5:0] OP_SH    = 6'd41;
  localparam logic [5:0] OP_SW    = 6'd43;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority forwarding mux for one source operand with load-use hazard flag
// Ports: i_dir/i_used/i_rf_data describe the operand; i_fwd_* are the packed forwarding
// sources (index 0 = youngest); o_data is the resolved operand, o_hazard flags a not-ready match.
module fwd_select #(
  parameter int NUM_FWD = 3,
  parameter int SIZE = 32,
  parameter int SIZE_REG_DIR = 5
) (
  input  logic [SIZE_REG_DIR-1:0]         i_dir,
  input  logic                            i_used,
  input  logic [SIZE-1:0]                 i_rf_data,
  input  logic [NUM_FWD*SIZE_REG_DIR-1:0] i_fwd_dir,
  input  logic [NUM_FWD-1:0]              i_fwd_we,
  input  logic [NUM_FWD-1:0]              i_fwd_ready,
  input  logic [NUM_FWD*SIZE-1:0]         i_fwd_data,
  output logic [SIZE-1:0]                 o_data,
  output logic                            o_hazard
);
  logic            hit;
  logic            rdy;
  logic [SIZE-1:0] sel;
  // Scan oldest to youngest so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    rdy = 1'b0;
    sel = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--)
      if (i_fwd_we[k] && i_fwd_dir[k*SIZE_REG_DIR +: SIZE_REG_DIR] == i_dir) begin
        hit = 1'b1;
        rdy = i_fwd_ready[k];
        sel = i_fwd_data[k*SIZE +: SIZE];
      end
    o_data   = (i_dir == '0) ? '0 : hit ? sel : i_rf_data;
    o_hazard = i_used && i_dir != '0 && hit && !rdy;
  end
endmodule

// File: rtl/register_bank.sv
// register_bank: register file, r0 hardwired to 0, two combinational read ports with write-through
// Ports: clk/rst (async active-low), write port i_write_enable/i_w_dir/i_w_data,
// read ports i_ra/i_rb -> o_ra/o_rb, o_registers flat dump (r0 in the low word).
module register_bank #(
  parameter int SIZE = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int SIZE_REG_DIR = $clog2(NUM_REGISTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_write_enable,
  input  logic [SIZE_REG_DIR-1:0]       i_w_dir,
  input  logic [SIZE-1:0]               i_w_data,
  input  logic [SIZE_REG_DIR-1:0]       i_ra,
  input  logic [SIZE_REG_DIR-1:0]       i_rb,
  output logic [SIZE-1:0]               o_ra,
  output logic [SIZE-1:0]               o_rb,
  output logic [SIZE*NUM_REGISTERS-1:0] o_registers
);
  logic [SIZE-1:0] mem_q [NUM_REGISTERS];
  logic            wr;
  assign wr = i_write_enable && i_w_dir != '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NUM_REGISTERS; i++) mem_q[i] <= '0;
    end else if (wr) begin
      mem_q[i_w_dir] <= i_w_data;
    end
  assign o_ra = (wr && i_w_dir == i_ra) ? i_w_data : mem_q[i_ra];
  assign o_rb = (wr && i_w_dir == i_rb) ? i_w_data : mem_q[i_rb];
  for (genvar g = 0; g < NUM_REGISTERS; g++) begin : g_dump
    assign o_registers[g*SIZE +: SIZE] = mem_q[g];
  end
endmodule

// File: rtl/decode_stage_hazard.sv
// decode_stage_hazard: ID stage with register read, priority forwarding, load-use stall, ID branches and registered ID/EX
// Ports: IF/ID side (i_instruction, i_pc, i_valid, i_flush), pipeline control (i_stall_ext, o_stall_if),
// WB write port, forwarding sources i_fwd_*, redirect (o_branch_taken/o_branch_target),
// registered ID/EX fields o_*, hazard-stall counter and register-file dump.
module decode_stage_hazard
  import mips_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int NUM_REGISTERS = DEF_NUM_REGISTERS,
  parameter int SIZE_REG_DIR = $clog2(NUM_REGISTERS),
  parameter int SIZE_OP = 6,
  parameter int NUM_FWD = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SIZE-1:0]                 i_instruction,
  input  logic [SIZE-1:0]                 i_pc,
  input  logic                            i_valid,
  input  logic                            i_flush,
  input  logic                            i_stall_ext,
  input  logic                            i_write_enable,
  input  logic [SIZE_REG_DIR-1:0]         i_w_dir,
  input  logic [SIZE-1:0]                 i_w_data,
  input  logic [NUM_FWD*SIZE_REG_DIR-1:0] i_fwd_dir,
  input  logic [NUM_FWD-1:0]              i_fwd_we,
  input  logic [NUM_FWD-1:0]              i_fwd_ready,
  input  logic [NUM_FWD*SIZE-1:0]         i_fwd_data,
  output logic                            o_stall_if,
  output logic                            o_branch_taken,
  output logic [SIZE-1:0]                 o_branch_target,
  output logic                            o_valid,
  output logic [SIZE_OP-1:0]              o_op,
  output logic [SIZE-1:0]                 o_reg_A,
  output logic [SIZE-1:0]                 o_reg_B,
  output logic [SIZE-1:0]                 o_immediate,
  output logic [SIZE_REG_DIR-1:0]         o_dir_rs,
  output logic [SIZE_REG_DIR-1:0]         o_dir_rt,
  output logic [SIZE_REG_DIR-1:0]         o_dir_rd,
  output logic [SIZE-1:0]                 o_pc,
  output logic [25:0]                     o_jmp_direc,
  output logic [STALL_CNT_W-1:0]          o_stall_cycles,
  output logic [SIZE*NUM_REGISTERS-1:0]   o_registers_debug
);
  typedef struct packed {
    logic                    valid;
    logic [SIZE_OP-1:0]      op;
    logic [SIZE-1:0]         a;
    logic [SIZE-1:0]         b;
    logic [SIZE-1:0]         imm;
    logic [SIZE_REG_DIR-1:0] rs;
    logic [SIZE_REG_DIR-1:0] rt;
    logic [SIZE_REG_DIR-1:0] rd;
    logic [SIZE-1:0]         pc;
    logic [25:0]             jmp;
  } idex_t;
  idex_t                   idex_q, idex_d;
  logic [STALL_CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE_OP-1:0]      op;
  logic [SIZE_REG_DIR-1:0] rs, rt, rd;
  logic [SIZE-1:0]         imm, rf_a, rf_b, op_a, op_b;
  logic                    rs_used, rt_used, haz_a, haz_b, hazard_stall, branch_ok;
  assign op  = i_instruction[SIZE-1 -: SIZE_OP];
  assign rs  = i_instruction[25:21];
  assign rt  = i_instruction[20:16];
  assign rd  = i_instruction[15:11];
  assign imm = {{(SIZE-16){i_instruction[15]}}, i_instruction[15:0]};
  assign rs_used = !(op inside {OP_J, OP_JAL, OP_LUI});
  assign rt_used = op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW};
  register_bank #(.SIZE(SIZE), .NUM_REGISTERS(NUM_REGISTERS), .SIZE_REG_DIR(SIZE_REG_DIR)) u_rf (
    .clk(clk), .rst(rst), .i_write_enable(i_write_enable), .i_w_dir(i_w_dir), .i_w_data(i_w_data),
    .i_ra(rs), .i_rb(rt), .o_ra(rf_a), .o_rb(rf_b), .o_registers(o_registers_debug)
  );
  fwd_select #(.NUM_FWD(NUM_FWD), .SIZE(SIZE), .SIZE_REG_DIR(SIZE_REG_DIR)) u_fwd_a (
    .i_dir(rs), .i_used(rs_used), .i_rf_data(rf_a), .i_fwd_dir(i_fwd_dir), .i_fwd_we(i_fwd_we),
    .i_fwd_ready(i_fwd_ready), .i_fwd_data(i_fwd_data), .o_data(op_a), .o_hazard(haz_a)
  );
  fwd_select #(.NUM_FWD(NUM_FWD), .SIZE(SIZE), .SIZE_REG_DIR(SIZE_REG_DIR)) u_fwd_b (
    .i_dir(rt), .i_used(rt_used), .i_rf_data(rf_b), .i_fwd_dir(i_fwd_dir), .i_fwd_we(i_fwd_we),
    .i_fwd_ready(i_fwd_ready), .i_fwd_data(i_fwd_data), .o_data(op_b), .o_hazard(haz_b)
  );
  assign hazard_stall = i_valid && !i_flush && (haz_a || haz_b);
  assign branch_ok    = i_valid && !i_flush && !hazard_stall;
  assign o_stall_if   = hazard_stall;
  assign o_branch_taken = branch_ok && ((op == OP_BEQ && op_a == op_b) || (op == OP_BNE && op_a != op_b) ||
                                        op == OP_J || op == OP_JAL);
  assign o_branch_target = (op == OP_J || op == OP_JAL) ? {i_pc[SIZE-1:28], i_instruction[25:0], 2'b00}
                                                        : i_pc + (imm << 2);
  // External stall freezes ID/EX even when a flush or hazard is present.
  always_comb begin
    idex_d = idex_q;
    if (!i_stall_ext)
      idex_d = (i_flush || hazard_stall || !i_valid) ? '0 :
               '{valid: 1'b1, op: op, a: op_a, b: op_b, imm: imm, rs: rs, rt: rt, rd: rd,
                 pc: i_pc, jmp: i_instruction[25:0]};
    cnt_d = (hazard_stall && !i_stall_ext && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  assign o_valid        = idex_q.valid;
  assign o_op           = idex_q.op;
  assign o_reg_A        = idex_q.a;
  assign o_reg_B        = idex_q.b;
  assign o_immediate    = idex_q.imm;
  assign o_dir_rs       = idex_q.rs;
  assign o_dir_rt       = idex_q.rt;
  assign o_dir_rd       = idex_q.rd;
  assign o_pc           = idex_q.pc;
  assign o_jmp_direc    = idex_q.jmp;
  assign o_stall_cycles = cnt_q;
endmodule

// File: tb/tb_decode_stage_hazard.sv
// tb_decode_stage_hazard: directed vectors with a scoreboard queue for the registered ID/EX state
module tb_decode_stage_hazard;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  instr, pc;
  logic         valid, flush, stall_ext, we;
  logic [4:0]   w_dir;
  logic [31:0]  w_data;
  logic [14:0]  fwd_dir;
  logic [2:0]   fwd_we, fwd_rdy;
  logic [95:0]  fwd_data;
  logic         stall_if, taken, o_valid;
  logic [31:0]  target, reg_a, reg_b, immv, o_pc;
  logic [5:0]   o_op;
  logic [4:0]   d_rs, d_rt, d_rd;
  logic [25:0]  jmp;
  logic [3:0]   cnt;
  logic [1023:0] regs;
  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        v;
    logic [5:0]  op;
    logic [31:0] a, b, imm;
    logic [4:0]  rs, rt, rd;
    logic [31:0] pc;
    logic [25:0] jmp;
    logic [3:0]  cnt;
  } exp_t;
  exp_t q[$];

  decode_stage_hazard #(.STALL_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .i_instruction(instr), .i_pc(pc), .i_valid(valid), .i_flush(flush),
    .i_stall_ext(stall_ext), .i_write_enable(we), .i_w_dir(w_dir), .i_w_data(w_data),
    .i_fwd_dir(fwd_dir), .i_fwd_we(fwd_we), .i_fwd_ready(fwd_rdy), .i_fwd_data(fwd_data),
    .o_stall_if(stall_if), .o_branch_taken(taken), .o_branch_target(target), .o_valid(o_valid),
    .o_op(o_op), .o_reg_A(reg_a), .o_reg_B(reg_b), .o_immediate(immv), .o_dir_rs(d_rs),
    .o_dir_rt(d_rt), .o_dir_rd(d_rd), .o_pc(o_pc), .o_jmp_direc(jmp), .o_stall_cycles(cnt),
    .o_registers_debug(regs)
  );

  always #5 clk = ~clk;

  function automatic exp_t actual();
    return {o_valid, o_op, reg_a, reg_b, immv, d_rs, d_rt, d_rd, o_pc, jmp, cnt};
  endfunction

  function automatic exp_t mk(input logic [5:0] op, input logic [31:0] a, b, imm,
                              input logic [4:0] rs, rt, rd, input logic [31:0] p,
                              input logic [25:0] j, input logic [3:0] c);
    return '{v: 1'b1, op: op, a: a, b: b, imm: imm, rs: rs, rt: rt, rd: rd, pc: p, jmp: j, cnt: c};
  endfunction

  function automatic exp_t bub(input logic [3:0] c);
    exp_t e;
    e = '0;
    e.cnt = c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [1023:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic set_fwd(input int k, input logic [4:0] d, input logic w, r, input logic [31:0] dat);
    fwd_dir[k*5 +: 5]   = d;
    fwd_we[k]           = w;
    fwd_rdy[k]          = r;
    fwd_data[k*32 +: 32] = dat;
  endtask

  task automatic clr_fwd();
    fwd_dir = '0; fwd_we = '0; fwd_rdy = '0; fwd_data = '0;
  endtask

  // Drive one ID cycle at the negedge, check the combinational outputs, queue the ID/EX result.
  task automatic step(input string name, input logic [31:0] ins, p, input logic v, fl, se,
                      input logic e_stall, e_taken, input logic [31:0] e_tgt, input exp_t e);
    instr = ins; pc = p; valid = v; flush = fl; stall_ext = se;
    #1;
    chk({name, ".stall_if"}, 1024'(stall_if), 1024'(e_stall));
    chk({name, ".taken"}, 1024'(taken), 1024'(e_taken));
    if (e_taken) chk({name, ".target"}, 1024'(target), 1024'(e_tgt));
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: ID/EX is presented after every posedge; compare against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("idex", 1024'(actual()), 1024'(e));
      end
    end
  end

  initial begin
    exp_t jrec;
    logic [3:0] c;
    rst = 1'b0; instr = '0; pc = '0; valid = 1'b0; flush = 1'b0; stall_ext = 1'b0;
    we = 1'b0; w_dir = '0; w_data = '0;
    clr_fwd();
    #1;
    chk("reset_idex", 1024'(actual()), 1024'(exp_t'('0)));
    chk("reset_regs", regs, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // Priority: fwd0 wins over not-ready fwd1 and fwd2.
    set_fwd(0, 5'd1, 1'b1, 1'b1, 32'hAA);
    set_fwd(1, 5'd1, 1'b1, 1'b0, 32'h77);
    set_fwd(2, 5'd1, 1'b1, 1'b1, 32'h55);
    step("prio", 32'h00221820, 32'h40, 1, 0, 0, 0, 0, 0,
         mk(6'd0, 32'hAA, 32'h0, 32'h1820, 5'd1, 5'd2, 5'd3, 32'h40, 26'h0221820, 4'd0));
    // Load-use on rt, then the load returns.
    clr_fwd();
    set_fwd(0, 5'd2, 1'b1, 1'b0, 32'h0);
    step("loaduse", 32'h00A22020, 32'h44, 1, 0, 0, 1, 0, 0, bub(4'd1));
    set_fwd(0, 5'd2, 1'b1, 1'b1, 32'hBEEF);
    step("loaddone", 32'h00A22020, 32'h44, 1, 0, 0, 0, 0, 0,
         mk(6'd0, 32'h0, 32'hBEEF, 32'h2020, 5'd5, 5'd2, 5'd4, 32'h44, 26'h0A22020, 4'd1));
    clr_fwd();
    step("beq", 32'h10840003, 32'h100, 1, 0, 0, 0, 1, 32'h10C,
         mk(6'd4, 32'h0, 32'h0, 32'h3, 5'd4, 5'd4, 5'd0, 32'h100, 26'h0840003, 4'd1));
    step("bne", 32'h14840003, 32'h100, 1, 0, 0, 0, 0, 0,
         mk(6'd5, 32'h0, 32'h0, 32'h3, 5'd4, 5'd4, 5'd0, 32'h100, 26'h0840003, 4'd1));
    // r0 operands never stall even with a pending write to r0; negative offset.
    set_fwd(0, 5'd0, 1'b1, 1'b0, 32'h0);
    step("beq_r0", 32'h1000FFFF, 32'h100, 1, 0, 0, 0, 1, 32'hFC,
         mk(6'd4, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd31, 32'h100, 26'h000FFFF, 4'd1));
    // J ignores its rs field even when a not-ready source matches it.
    set_fwd(0, 5'd5, 1'b1, 1'b0, 32'h0);
    jrec = mk(6'd2, 32'h0, 32'h0, 32'h40, 5'd5, 5'd0, 5'd0, 32'hA0000010, 26'h0A00040, 4'd1);
    step("jump", 32'h08A00040, 32'hA0000010, 1, 0, 0, 0, 1, 32'hA2800100, jrec);
    // External stall holds ID/EX and the counter, with hazard and with flush.
    set_fwd(0, 5'd2, 1'b1, 1'b0, 32'h0);
    step("ext_haz", 32'h00A22020, 32'h48, 1, 0, 1, 1, 0, 0, jrec);
    step("ext_flush", 32'h00A22020, 32'h48, 1, 1, 1, 0, 0, 0, jrec);
    step("haz", 32'h00A22020, 32'h48, 1, 0, 0, 1, 0, 0, bub(4'd2));
    step("flush", 32'h00A22020, 32'h48, 1, 1, 0, 0, 0, 0, bub(4'd2));
    clr_fwd();
    step("bubble", 32'h10840003, 32'h100, 0, 0, 0, 0, 0, 0, bub(4'd2));
    // Write-through on r7, then write to r0 is dropped.
    we = 1'b1; w_dir = 5'd7; w_data = 32'h1234;
    step("wthru", 32'h00E00820, 32'h50, 1, 0, 0, 0, 0, 0,
         mk(6'd0, 32'h1234, 32'h0, 32'h0820, 5'd7, 5'd0, 5'd1, 32'h50, 26'h0E00820, 4'd2));
    w_dir = 5'd0; w_data = 32'hDEAD;
    step("wr_r0", 32'h00070820, 32'h54, 1, 0, 0, 0, 0, 0,
         mk(6'd0, 32'h0, 32'h1234, 32'h0820, 5'd0, 5'd7, 5'd1, 32'h54, 26'h0070820, 4'd2));
    we = 1'b0;
    chk("rf_r7", 1024'(regs[7*32 +: 32]), 1024'(32'h1234));
    chk("rf_r0", 1024'(regs[31:0]), 1024'(32'h0));
    // Sustained hazard drives the counter into saturation.
    set_fwd(0, 5'd2, 1'b1, 1'b0, 32'h0);
    c = 4'd2;
    for (int i = 0; i < 15; i++) begin
      c = (c == 4'hF) ? c : c + 4'd1;
      step("sat", 32'h00A22020, 32'h58, 1, 0, 0, 1, 0, 0, bub(c));
    end
    // Asynchronous reset mid-stall clears everything, including the register file.
    rst = 1'b0;
    #1;
    chk("midreset_idex", 1024'(actual()), 1024'(exp_t'('0)));
    chk("midreset_regs", regs, '0);
    @(negedge clk);
    rst = 1'b1;
    clr_fwd();
    step("after_rst", 32'h00E50820, 32'h60, 1, 0, 0, 0, 0, 0,
         mk(6'd0, 32'h0, 32'h0, 32'h0820, 5'd7, 5'd5, 5'd1, 32'h60, 26'h0E50820, 4'd0));
    valid = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
